// File: rtl/pi_loop_sequencer.sv
// pi_loop_sequencer: runs one PI iteration per ADC sample through an external pipeline and
// hands the clamped-integral result to the DAC writer over valid/ready.
module pi_loop_sequencer #(
  parameter int INPUT_WIDTH = 18,
  parameter int OUTPUT_WIDTH = 32,
  parameter int DAC_WIDTH = 20,
  parameter int PIPELINE_LATENCY = 6,
  parameter logic signed [OUTPUT_WIDTH-1:0] INTEGRAL_LIMIT = 32'sh0FFFFFFF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           adc_valid,
  output logic                           adc_ready,
  input  logic signed [INPUT_WIDTH-1:0]  adc_data,
  input  logic signed [INPUT_WIDTH-1:0]  setpoint,
  input  logic signed [OUTPUT_WIDTH-1:0] kp,
  input  logic signed [OUTPUT_WIDTH-1:0] ki,
  output logic signed [INPUT_WIDTH-1:0]  pipe_setpoint,
  output logic signed [INPUT_WIDTH-1:0]  pipe_actual,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_kp,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_ki,
  output logic signed [OUTPUT_WIDTH-1:0] pipe_integral_input,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_integral_result,
  input  logic signed [OUTPUT_WIDTH-1:0] pipe_pi_result,
  output logic                           dac_valid,
  input  logic                           dac_ready,
  output logic [DAC_WIDTH-1:0]           dac_data,
  output logic signed [OUTPUT_WIDTH-1:0] integral,
  output logic                           busy,
  output logic                           overrun,
  input  logic                           clear_overrun
);
  localparam int CW = $clog2(PIPELINE_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, EMIT} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic signed [OUTPUT_WIDTH-1:0] clamped;
  assign adc_ready = enable && state == IDLE && !rst;
  assign busy = state != IDLE;
  assign pipe_integral_input = integral;
  always_comb clamped = pipe_integral_result > INTEGRAL_LIMIT ? INTEGRAL_LIMIT :
                        pipe_integral_result < -INTEGRAL_LIMIT ? -INTEGRAL_LIMIT : pipe_integral_result;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pipe_setpoint <= '0;
      pipe_actual <= '0;
      pipe_kp <= '0;
      pipe_ki <= '0;
      integral <= '0;
      dac_valid <= 1'b0;
      dac_data <= '0;
      overrun <= 1'b0;
    end else begin
      if (enable && adc_valid && !adc_ready) overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
      // dropping enable aborts the iteration but keeps the pipeline inputs as they were
      if (!enable) begin
        state <= IDLE;
        dac_valid <= 1'b0;
        integral <= '0;
      end else if (state == IDLE) begin
        if (adc_valid) begin
          pipe_setpoint <= setpoint;
          pipe_actual <= adc_data;
          pipe_kp <= kp;
          pipe_ki <= ki;
          count <= CW'(PIPELINE_LATENCY);
          state <= WAIT;
        end
      end else if (state == WAIT) begin
        if (count == '0) begin
          dac_data <= pipe_pi_result[DAC_WIDTH-1:0];
          integral <= clamped;
          dac_valid <= 1'b1;
          state <= EMIT;
        end else count <= count - 1'b1;
      end else if (dac_ready) begin
        dac_valid <= 1'b0;
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pi_loop_sequencer.sv
// tb_pi_loop_sequencer: two sequencers (default limit and limit 50) share stimulus; each drives
// its own behavioural pi_pipeline and is checked every cycle against an iteration-level model.
module tb_pi_loop_sequencer;
  localparam int LAT = 6;
  logic clk = 0, rst = 1, enable = 1, adc_valid = 0, dac_ready = 1, clear_overrun = 0;
  logic signed [17:0] adc_data = 0, setpoint = 0;
  logic signed [31:0] kp = 0, ki = 0;
  logic rdy[2], dv[2], bsy[2], ovr[2];
  logic [19:0] dd[2];
  logic signed [17:0] psp[2], pact[2];
  logic signed [31:0] pkp[2], pki[2], pint[2], ppi[2], pir[2], intg[2], perr[2];
  logic signed [31:0] pr[2][LAT] = '{default: '0}, ir[2][LAT] = '{default: '0};
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    pi_loop_sequencer #(.INTEGRAL_LIMIT(g == 0 ? 32'sh0FFFFFFF : 32'sd50)) dut (
      .clk(clk), .rst(rst), .enable(enable), .adc_valid(adc_valid), .adc_ready(rdy[g]),
      .adc_data(adc_data), .setpoint(setpoint), .kp(kp), .ki(ki),
      .pipe_setpoint(psp[g]), .pipe_actual(pact[g]), .pipe_kp(pkp[g]), .pipe_ki(pki[g]),
      .pipe_integral_input(pint[g]), .pipe_integral_result(pir[g]), .pipe_pi_result(ppi[g]),
      .dac_valid(dv[g]), .dac_ready(dac_ready), .dac_data(dd[g]), .integral(intg[g]),
      .busy(bsy[g]), .overrun(ovr[g]), .clear_overrun(clear_overrun));
    assign perr[g] = pact[g] - psp[g];
    assign ppi[g] = pr[g][LAT-1];
    assign pir[g] = ir[g][LAT-1];
  end
  // pipeline stand-in: error = actual - setpoint, integral accumulates error, pi = kp*e + ki*integral
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      pr[i][0] <= pkp[i] * perr[i] + pki[i] * (pint[i] + perr[i]);
      ir[i][0] <= pint[i] + perr[i];
      for (int j = 1; j < LAT; j++) begin
        pr[i][j] <= pr[i][j-1];
        ir[i][j] <= ir[i][j-1];
      end
    end
  // iteration model: accept, wait LAT+1 edges, emit until handshake
  longint lim[2] = '{268435455, 50};
  longint m_int[2] = '{0, 0}, m_err[2], m_kp[2], m_ki[2], sum, pi;
  int m_age[2];
  bit m_busy[2] = '{0, 0}, m_valid[2] = '{0, 0}, m_ovr[2] = '{0, 0}, ready;
  logic [19:0] m_dac[2] = '{20'd0, 20'd0};
  always @(posedge clk or posedge rst)
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] = 0; m_valid[i] = 0; m_ovr[i] = 0; m_int[i] = 0; m_dac[i] = 0; m_age[i] = 0;
      end else begin
        ready = enable && !m_busy[i];
        if (enable && adc_valid && !ready) m_ovr[i] = 1;
        else if (clear_overrun) m_ovr[i] = 0;
        if (!enable) begin
          m_busy[i] = 0; m_valid[i] = 0; m_int[i] = 0;
        end else if (!m_busy[i]) begin
          if (adc_valid) begin
            m_busy[i] = 1; m_age[i] = 0;
            m_err[i] = longint'(adc_data) - longint'(setpoint);
            m_kp[i] = kp; m_ki[i] = ki;
          end
        end else if (!m_valid[i]) begin
          if (m_age[i] == LAT) begin
            sum = m_int[i] + m_err[i];
            pi = m_kp[i] * m_err[i] + m_ki[i] * sum;
            m_dac[i] = pi[19:0];
            m_int[i] = sum > lim[i] ? lim[i] : sum < -lim[i] ? -lim[i] : sum;
            m_valid[i] = 1;
          end else m_age[i]++;
        end else if (dac_ready) begin
          m_valid[i] = 0; m_busy[i] = 0;
        end
      end
    end
  task automatic chk(input string n, input logic signed [63:0] a, input logic signed [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (!rst)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("adc_ready[%0d]", i), rdy[i], enable && !m_busy[i]);
        chk($sformatf("busy[%0d]", i), bsy[i], m_busy[i]);
        chk($sformatf("dac_valid[%0d]", i), dv[i], m_valid[i]);
        chk($sformatf("dac_data[%0d]", i), dd[i], m_dac[i]);
        chk($sformatf("integral[%0d]", i), intg[i], m_int[i]);
        chk($sformatf("pipe_integral_input[%0d]", i), pint[i], m_int[i]);
        chk($sformatf("overrun[%0d]", i), ovr[i], m_ovr[i]);
      end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut;
    rst = 1;
    step;
    step;
    rst = 0;
    step;
  endtask
  task automatic run(input int sp, input int act, input int p, input int i);
    int lat;
    setpoint = sp[17:0]; adc_data = act[17:0]; kp = p; ki = i; adc_valid = 1;
    step;
    adc_valid = 0;
    lat = 0;
    while (!dv[0] && lat < 20) begin
      step;
      lat++;
    end
    chk("latency", lat, 7);
    if (dac_ready) step;
  endtask
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    reset_dut;
    chk("reset adc_ready", rdy[0], 1);
    chk("reset integral", intg[0], 0);
    chk("reset dac_valid", dv[0], 0);
    // proportional path, and clamp on the limit-50 instance
    run(0, 100, 2, 0);
    chk("p dac_data", dd[0], 200);
    chk("p integral", intg[0], 100);
    chk("p integral lim50", intg[1], 50);
    // async reset in the middle of WAIT
    setpoint = 0; adc_data = 100; kp = 2; ki = 0; adc_valid = 1;
    step;
    adc_valid = 0;
    repeat (3) step;
    #2 rst = 1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst dac_valid", dv[i], 0);
      chk("rst integral", intg[i], 0);
      chk("rst busy", bsy[i], 0);
      chk("rst adc_ready", rdy[i], 0);
    end
    #1 rst = 0;
    step;
    chk("post-rst adc_ready", rdy[0], 1);
    repeat (10) step;
    // integral path
    reset_dut;
    run(0, 10, 0, 1);
    chk("i1 dac_data", dd[0], 10);
    run(0, 10, 0, 1);
    chk("i2 dac_data", dd[0], 20);
    run(0, 10, 0, 1);
    chk("i3 dac_data", dd[0], 30);
    chk("i3 integral", intg[0], 30);
    // anti-windup on the limit-50 instance
    reset_dut;
    run(0, 40, 0, 1);
    chk("w1 integral lim50", intg[1], 40);
    run(0, 40, 0, 1);
    chk("w2 dac_data lim50", dd[1], 80);
    chk("w2 integral lim50", intg[1], 50);
    chk("w2 integral", intg[0], 80);
    run(0, -200, 0, 1);
    chk("w3 integral lim50", intg[1], -50);
    chk("w3 dac_data lim50", dd[1], 20'hFFF6A);
    chk("w3 integral", intg[0], -120);
    // back-pressure in EMIT, overrun set and cleared
    dac_ready = 0;
    run(0, 5, 1, 0);
    begin
      logic [19:0] held;
      held = dd[0];
      step;
      adc_valid = 1;
      step;
      adc_valid = 0;
      chk("overrun set", ovr[0], 1);
      clear_overrun = 1;
      step;
      clear_overrun = 0;
      chk("overrun clear", ovr[0], 0);
      step;
      step;
      chk("emit held dac_data", dd[0], held);
      chk("emit held dac_valid", dv[0], 1);
      dac_ready = 1;
      step;
      chk("emit release busy", bsy[0], 0);
    end
    // abort at WAIT count 3, then a clean iteration
    setpoint = 0; adc_data = 7; kp = 1; ki = 1; adc_valid = 1;
    step;
    adc_valid = 0;
    repeat (3) step;
    enable = 0;
    step;
    chk("abort busy", bsy[0], 0);
    chk("abort integral", intg[0], 0);
    adc_valid = 1;
    repeat (5) step;
    chk("disabled overrun", ovr[0], 0);
    adc_valid = 0;
    repeat (5) step;
    enable = 1;
    step;
    run(0, 10, 0, 1);
    chk("re-enable dac_data", dd[0], 10);
    chk("re-enable integral", intg[0], 10);
    step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
